program_loader: RTL



---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_ram_16x8.sv | 37 +++
 rtl/program_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader: frame constants, RAM geometry,
//   the loader state encoding and a length-validity helper.
//   No ports (package).
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         DEPTH     = 16;
    localparam int         AW        = 4;
    localparam int         DW        = 8;
    localparam int         MAX_LEN   = 16;

    // Fixed encodings so the debug view of the state is stable for checkers.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_LEN  = 3'd1,
        S_DATA     = 3'd2,
        S_GET_CSUM = 3'd3,
        S_CHECK    = 3'd4,
        S_RUN      = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    // A length byte is usable when it names 1..MAX_LEN words.
    function automatic logic len_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(MAX_LEN));
    endfunction

endpackage

// File: rtl/program_ram_16x8.sv
// program_ram_16x8
//   16x8 program store: synchronous write, asynchronous read, synchronous clear.
//   Ports:
//     CK  in  1  clock
//     RST in  1  synchronous clear of every word to 8'h00
//     WE  in  1  write enable
//     WA  in  4  write address
//     WD  in  8  write data
//     AD  in  4  read address
//     Q   out 8  read data (combinational; shows old word during a write)
module program_ram_16x8
    import program_loader_pkg::*;
(
    input  logic          CK,
    input  logic          RST,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic [AW-1:0] AD,
    output logic [DW-1:0] Q
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE) begin
            mem[WA] <= WD;
        end
    end

    assign Q = mem[AD];

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed byte stream (SYNC, LENGTH, data..., CSUM), writes the
//   data into the program RAM and releases the CPU once the checksum matches.
//   The CPU fetches through the AD->Q asynchronous read port.
//   Ports:
//     CK        in  1   clock
//     RST       in  1   synchronous active-high reset
//     DIN       in  8   stream byte
//     DIN_VALID in  1   DIN holds a byte
//     DIN_READY out 1   loader can take a byte
//     AD        in  4   CPU fetch address
//     Q         out 8   instruction at AD
//     CPU_RST   out 1   holds the CPU in reset (low only in RUN)
//     DONE      out 1   program loaded and verified
//     ERR       out 1   last frame rejected
//     LEN       out 5   word count from the last accepted length byte
//     state_dbg out 3   current loader state encoding
//
// Handshake: a byte moves on a rising CK edge where DIN_VALID and DIN_READY
// are both 1. The producer holds DIN stable while DIN_VALID is high and not
// yet accepted; DIN_READY is low only during the single CHECK cycle.
module program_loader
    import program_loader_pkg::*;
(
    input  logic          CK,
    input  logic          RST,
    input  logic [7:0]    DIN,
    input  logic          DIN_VALID,
    output logic          DIN_READY,
    input  logic [AW-1:0] AD,
    output logic [DW-1:0] Q,
    output logic          CPU_RST,
    output logic          DONE,
    output logic          ERR,
    output logic [4:0]    LEN,
    output logic [2:0]    state_dbg
);

    state_t     state, state_next;
    logic [4:0] idx;
    logic [7:0] sum;
    logic [7:0] csum_reg;
    logic       xfer;
    logic       ram_we;

    assign xfer = DIN_VALID & DIN_READY;

    // State register. CPU_RST is registered from the next state so it changes
    // on the same edge that enters or leaves RUN.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= S_IDLE;
            CPU_RST <= 1'b1;
        end else begin
            state   <= state_next;
            CPU_RST <= (state_next != S_RUN);
        end
    end

    // Next-state logic. Everything except CHECK waits for a transfer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (xfer && DIN == SYNC_BYTE) state_next = S_GET_LEN;
            end
            S_GET_LEN: begin
                if (xfer) state_next = len_ok(DIN) ? S_DATA : S_ERR;
            end
            S_DATA: begin
                // No resync inside a frame: SYNC-valued bytes are plain data.
                if (xfer && idx == (LEN - 5'd1)) state_next = S_GET_CSUM;
            end
            S_GET_CSUM: begin
                if (xfer) state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = (sum == csum_reg) ? S_RUN : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        DIN_READY = (state != S_CHECK);
        DONE      = (state == S_RUN);
        ERR       = (state == S_ERR);
        ram_we    = (state == S_DATA) && xfer;
        state_dbg = state;
    end

    // Index, running checksum, received checksum and length.
    always_ff @(posedge CK) begin
        if (RST) begin
            idx      <= '0;
            sum      <= '0;
            csum_reg <= '0;
            LEN      <= '0;
        end else if (xfer) begin
            case (state)
                S_GET_LEN: begin
                    if (len_ok(DIN)) begin
                        LEN <= DIN[4:0];
                        idx <= '0;
                        sum <= '0;
                    end
                end
                S_DATA: begin
                    sum <= sum + DIN;
                    idx <= idx + 5'd1;
                end
                S_GET_CSUM: csum_reg <= DIN;
                default: ;
            endcase
        end
    end

    // idx reaches 16 only after the last word of a 16-word frame, and no
    // write happens then, so the low four bits address the RAM directly.
    program_ram_16x8 u_ram (
        .CK (CK),
        .RST(RST),
        .WE (ram_we),
        .WA (idx[3:0]),
        .WD (DIN),
        .AD (AD),
        .Q  (Q)
    );

endmodule
